// File: rtl/prime_check_if.sv
// Request/response bus between prime_check (requester) and the divmod unit.
interface prime_check_if #(
    parameter int W = 16
);
    logic         dm_go;
    logic [W-1:0] dm_a;
    logic [W-1:0] dm_b;
    logic         dm_ready;
    logic         dm_error;
    logic [W-1:0] dm_div;
    logic [W-1:0] dm_mod;

    modport master (
        output dm_go, dm_a, dm_b,
        input  dm_ready, dm_error, dm_div, dm_mod
    );

    modport slave (
        input  dm_go, dm_a, dm_b,
        output dm_ready, dm_error, dm_div, dm_mod
    );
endinterface

// File: rtl/prime_check.sv
// Trial-division primality tester driving a shared divmod unit with n/d requests
// for d = 2, 3, ...; the sqrt bound comes from comparing the quotient against d.
module prime_check #(
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [W-1:0]  n,
    output logic          ready,
    output logic          is_prime,
    output logic [W-1:0]  factor,
    output logic          error,
    prime_check_if.master dm
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EVAL} state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] n_r;
    logic [W-1:0] d;
    logic         wait_first;
    logic         accept;
    logic         issue_fire;
    logic         eval_done;

    assign accept    = (state == IDLE) && ready && go;
    assign eval_done = dm.dm_error || (dm.dm_div < d) || (dm.dm_mod == '0);

    assign dm.dm_go = issue_fire;
    assign dm.dm_a  = n_r;
    assign dm.dm_b  = d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            is_prime   <= 1'b0;
            factor     <= '0;
            error      <= 1'b0;
            n_r        <= '0;
            d          <= '0;
            wait_first <= 1'b0;
        end else begin
            state      <= state_next;
            wait_first <= issue_fire;
            case (state)
                IDLE: begin
                    // A candidate below 2 keeps us in IDLE, so ready drops for one cycle only.
                    if (accept) begin
                        n_r      <= n;
                        d        <= W'(2);
                        is_prime <= 1'b0;
                        factor   <= '0;
                        error    <= 1'b0;
                        ready    <= 1'b0;
                    end else begin
                        ready    <= 1'b1;
                    end
                end
                EVAL: begin
                    if (dm.dm_error) begin
                        error    <= 1'b1;
                        ready    <= 1'b1;
                    end else if (dm.dm_div < d) begin
                        is_prime <= 1'b1;
                        ready    <= 1'b1;
                    end else if (dm.dm_mod == '0) begin
                        factor   <= d;
                        ready    <= 1'b1;
                    end else begin
                        d        <= d + W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        issue_fire = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (n >= W'(2))) state_next = ISSUE;
            end
            ISSUE: begin
                if (dm.dm_ready) begin
                    issue_fire = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // divmod is still dropping ready in the first WAIT cycle.
                if (!wait_first && dm.dm_ready) state_next = EVAL;
            end
            EVAL: begin
                state_next = eval_done ? IDLE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_prime_check.sv
// Bench for prime_check: divmod model with selectable busy latency, reference
// primality model, per-cycle compare process and directed literal vectors.
module tb_prime_check;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go  = 1'b0;
    logic [W-1:0] n   = '0;
    logic         ready;
    logic         is_prime;
    logic [W-1:0] factor;
    logic         error;

    prime_check_if #(.W(W)) dm_bus ();

    prime_check #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .n        (n),
        .ready    (ready),
        .is_prime (is_prime),
        .factor   (factor),
        .error    (error),
        .dm       (dm_bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // divmod model
    int           dm_lat    = 1;
    bit           force_err = 1'b0;
    int           busy      = 0;
    logic         m_ready   = 1'b1;
    logic         m_err     = 1'b0;
    logic [W-1:0] m_div     = '0;
    logic [W-1:0] m_mod     = '0;

    assign dm_bus.dm_ready = m_ready;
    assign dm_bus.dm_error = m_err;
    assign dm_bus.dm_div   = m_div;
    assign dm_bus.dm_mod   = m_mod;

    always @(posedge clk) begin
        if (m_ready && dm_bus.dm_go) begin
            m_ready <= 1'b0;
            busy    <= dm_lat;
            if (force_err || dm_bus.dm_b == '0) begin
                m_err <= 1'b1;
                m_div <= '0;
                m_mod <= '0;
            end else begin
                m_err <= 1'b0;
                m_div <= dm_bus.dm_a / dm_bus.dm_b;
                m_mod <= dm_bus.dm_a % dm_bus.dm_b;
            end
        end else if (!m_ready) begin
            if (busy <= 1) m_ready <= 1'b1;
            busy <= busy - 1;
        end
    end

    // expected result state
    bit exp_valid  = 1'b0;
    bit exp_prime  = 1'b0;
    int exp_factor = 0;
    bit exp_error  = 1'b0;
    int cur_n      = 0;
    int run_base   = 0;
    int pulse_total = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (n=%0d lat=%0d t=%0t)",
                     name, actual, expected, cur_n, dm_lat, $time);
        end
    endtask

    // Reference: smallest divisor d with d*d <= val, else prime; trials = last d tried - 1.
    function automatic void ref_check(input int val, input bit err, output bit p,
                                      output int f, output bit e, output int trials);
        p = 1'b0; f = 0; e = 1'b0; trials = 0;
        if (val < 2) return;
        if (err) begin
            e = 1'b1;
            trials = 1;
            return;
        end
        for (int k = 2; k <= 70000; k++) begin
            if (k * k > val) begin
                p = 1'b1;
                trials = k - 1;
                return;
            end
            if (val % k == 0) begin
                f = k;
                trials = k - 1;
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (ready && exp_valid) begin
                checkOutput("is_prime", is_prime, exp_prime);
                checkOutput("factor", factor, exp_factor);
                checkOutput("error", error, exp_error);
                checkOutput("dm_go_idle", dm_bus.dm_go, 0);
            end
            if (dm_bus.dm_go) begin
                checkOutput("dm_go_without_ready", dm_bus.dm_ready, 1);
                checkOutput("dm_a", dm_bus.dm_a, cur_n);
                checkOutput("dm_b", dm_bus.dm_b, 2 + pulse_total - run_base);
                pulse_total++;
            end
        end
    end

    task automatic applyStimulus(input int val, input int lit_prime, input int lit_factor,
                                 input int lit_pulses, input int interfere);
        bit p, e;
        int f, t, low;
        ref_check(val, force_err, p, f, e, t);
        if (lit_prime >= 0) begin
            checkOutput("model_prime", p, lit_prime);
            checkOutput("model_factor", f, lit_factor);
            checkOutput("model_trials", t, lit_pulses);
        end
        @(negedge clk);
        n        = W'(val);
        go       = 1'b1;
        run_base = pulse_total;
        cur_n    = val;
        @(posedge clk);
        #1;
        go         = 1'b0;
        n          = W'($urandom);
        exp_valid  = 1'b1;
        exp_prime  = p;
        exp_factor = f;
        exp_error  = e;
        checkOutput("accept_drops_ready", ready, 0);
        low = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
            if (interfere > 0 && low == interfere) begin
                go = 1'b1;
                n  = W'(50);
            end else begin
                go = 1'b0;
            end
        end
        go = 1'b0;
        checkOutput("ready_timeout", ready, 1);
        checkOutput("latency", low, (val < 2) ? 1 : t * (dm_lat + 3));
        checkOutput("pulses", pulse_total - run_base, t);
        if (lit_prime >= 0) begin
            checkOutput("lit_pulses", pulse_total - run_base, lit_pulses);
            checkOutput("lit_is_prime", is_prime, lit_prime);
            checkOutput("lit_factor", factor, lit_factor);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ready"}, ready, 1);
        checkOutput({tag, "_is_prime"}, is_prime, 0);
        checkOutput({tag, "_factor"}, factor, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_dm_go"}, dm_bus.dm_go, 0);
        checkOutput({tag, "_dm_a"}, dm_bus.dm_a, 0);
        checkOutput({tag, "_dm_b"}, dm_bus.dm_b, 0);
    endtask

    task automatic resetMidRun();
        @(negedge clk);
        n        = W'(65521);
        go       = 1'b1;
        run_base = pulse_total;
        cur_n    = 65521;
        @(posedge clk);
        #1;
        go        = 1'b0;
        exp_valid = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("midrun_busy", ready, 0);
        #2;
        rst = 1'b0;
        #1;
        checkReset("async_reset");
        exp_prime  = 1'b0;
        exp_factor = 0;
        exp_error  = 1'b0;
        exp_valid  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checkReset("after_release");
    endtask

    initial begin
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b1;
        exp_valid = 1'b1;

        for (int pass = 0; pass < 2; pass++) begin
            dm_lat = (pass == 0) ? 1 : 5;
            $display("[TB] directed vectors, divmod latency %0d", dm_lat);
            applyStimulus(0, 0, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(2, 1, 0, 1, 0);
            applyStimulus(4, 0, 2, 1, 0);
            applyStimulus(97, 1, 0, 9, 0);
            applyStimulus(91, 0, 7, 6, 0);
            applyStimulus(65521, 1, 0, 255, 0);
            applyStimulus(65535, 0, 3, 2, 0);
            applyStimulus(97, 1, 0, 9, 3);
            force_err = 1'b1;
            applyStimulus(97, 0, 0, 1, 0);
            checkOutput("error_flag", error, 1);
            checkOutput("error_ready", ready, 1);
            force_err = 1'b0;
            resetMidRun();
            applyStimulus(91, 0, 7, 6, 0);
        end

        dm_lat = 1;
        $display("[TB] sweep n=0..1000");
        for (int v = 0; v <= 1000; v++) begin
            applyStimulus(v, -1, -1, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prime_check.md
Name: prime_check

Overview:
- Trial-division primality tester that sits directly upstream of the divmod unit and acts as its only requester.
- Accepts a candidate n, then issues successive n/d requests to divmod for d = 2, 3, 4, …
- Consumes divmod's quotient and remainder and reports prime or composite, plus the smallest factor found.
- The prime-generator top level sequences candidates through this block.

Parameters:
- W, 16, operand width; must match divmod's a/b width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled on posedge only while ready=1.
- n  in  W  candidate; captured on the accepted go.
- ready  out  1  idle/result-valid; high when results are valid and a new go is accepted.
- is_prime  out  1  candidate is prime; valid while ready=1.
- factor  out  W  smallest divisor found (0 if prime or n<2); valid while ready=1.
- error  out  1  divmod reported error during the run; valid while ready=1.
- dm_go  out  1  one-cycle request pulse to divmod.
- dm_a  out  W  dividend to divmod (= latched n).
- dm_b  out  W  divisor to divmod (= current d).
- dm_ready  in  1  divmod ready.
- dm_error  in  1  divmod error (divide by zero).
- dm_div  in  W  divmod quotient.
- dm_mod  in  W  divmod remainder.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, is_prime=0, factor=0, error=0, dm_go=0, dm_a=0, dm_b=0, internal n_r=0, d=0. Takes effect immediately, including mid-run; the run is abandoned and any pending divmod result is discarded.
- divmod contract:
  - dm_go is honoured only when dm_ready=1.
  - dm_ready falls the cycle after dm_go is sampled and stays low for at least 1 cycle.
  - When dm_ready rises, dm_div/dm_mod are valid and held.
- States: IDLE, ISSUE, WAIT, EVAL.
- IDLE (ready=1):
  - On go=1: latch n_r=n, d=2; clear is_prime/factor/error; ready=0 next cycle.
  - If n<2: go directly to IDLE with is_prime=0, factor=0, so ready returns after 1 cycle low.
  - Else: go to ISSUE.
- ISSUE:
  - Wait until dm_ready=1.
  - Then drive dm_go=1 for exactly one cycle, with dm_a=n_r and dm_b=d held stable from that cycle through WAIT.
  - Go to WAIT.
- WAIT:
  - First cycle is unconditional (divmod is dropping ready).
  - Then stay until dm_ready=1, then go to EVAL.
- EVAL (single cycle), priority order:
  1. dm_error=1 → error=1, is_prime=0, IDLE.
  2. dm_div < d (i.e. d*d > n) → is_prime=1, IDLE.
  3. dm_mod == 0 → is_prime=0, factor=d, IDLE.
  4. Otherwise d=d+1 → ISSUE.
- No multiplier is used; the square-root bound comes from the quotient compare.
- d never wraps: for n ≤ 2^W−1, the quotient-compare exit fires before d exceeds 2^(W/2).
- Latency:
  - One trial takes 1 (ISSUE, if dm_ready already high) + divmod busy cycles + 1 (WAIT exit) + 1 (EVAL).
  - Total = trials × per-trial cost + 1 accept cycle.
- go while ready=0 is ignored; n is not resampled.
- Outputs is_prime/factor/error hold from the return to IDLE until the next accepted go.
- dm_go is never asserted outside ISSUE; it is never asserted twice per trial.

Test Plan:
- Use a bench model of divmod with configurable busy latency of 1 and 5 cycles; run every scenario at both latencies.
- Reset → ready=1, is_prime=0, factor=0, error=0, dm_go=0. go with n=0, then n=1 → ready low 1 cycle, is_prime=0, factor=0, zero dm_go pulses.
- n=2 → 1 trial (2/2 quotient 1 < 2) → is_prime=1, factor=0. n=4 → 1 trial → is_prime=0, factor=2.
- n=97 → exactly 9 dm_go pulses (d=2..10) → is_prime=1. n=91 → 6 pulses → is_prime=0, factor=7.
- n=65521 → 255 pulses (d=2..256) → is_prime=1. n=65535 → 2 pulses → factor=3.
- Stuck-at-zero model forcing dm_error=1 → error=1, is_prime=0, ready=1.
- Concurrency and reset:
  - Pulse go with n=50 during a run of n=97 → the n=97 result is unaffected.
  - Assert rst mid-run of n=65521 → outputs return to reset values asynchronously.
  - After release, n=91 → correct result (factor=7).
  - Exhaustive n=0..1000 against a reference primality model.
